// File: rtl/poly_collect12_if.sv
// Coefficient-pair input and random-access read bus
// for the 12-bit polynomial collector.
interface poly_collect12_if;
   logic        in_valid;
   logic [15:0] in_coef0;
   logic [15:0] in_coef1;
   logic [15:0] in_index;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [11:0] rd_data;
   logic        rd_valid;

   modport master (
      output in_valid, in_coef0, in_coef1, in_index,
      output rd_en, rd_addr,
      input  rd_data, rd_valid
   );

   modport slave (
      input  in_valid, in_coef0, in_coef1, in_index,
      input  rd_en, rd_addr,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/poly_collect12.sv
// Collects decoded coefficient pairs into a 256 x 12-bit polynomial
// buffer, checks range and pair order, and serves random-access reads.
module poly_collect12 #(
   parameter int Q      = 3329,
   parameter int NPAIRS = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   poly_collect12_if.slave   bus,
   output logic [7:0]        pair_count,
   output logic              full,
   output logic              poly_done,
   output logic              range_err,
   output logic              index_err,
   output logic              overflow
);

   typedef enum logic {S_COLLECT, S_FULL} state_t;

   localparam logic [11:0] QV   = 12'(Q);
   localparam logic [7:0]  LAST = 8'(NPAIRS - 1);

   state_t      state, state_nx;
   logic        wr;
   logic        ovf;
   logic        last;
   logic [6:0]  row;
   logic [11:0] even_mem [NPAIRS];
   logic [11:0] odd_mem  [NPAIRS];

   function automatic logic bad(input logic [15:0] c);
      return (c[15:12] != 4'd0) || (c[11:0] >= QV);
   endfunction

   assign last = (pair_count == LAST);
   assign row  = pair_count[6:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_COLLECT;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (clear)
         state_nx = S_COLLECT;
      else if (state == S_COLLECT && bus.in_valid && last)
         state_nx = S_FULL;
   end

   always_comb begin
      full = (state == S_FULL);
      wr   = (state == S_COLLECT) && bus.in_valid && !clear;
      ovf  = (state == S_FULL) && bus.in_valid && !clear;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pair_count <= '0;
         poly_done  <= 1'b0;
         range_err  <= 1'b0;
         index_err  <= 1'b0;
         overflow   <= 1'b0;
      end else if (clear) begin
         pair_count <= '0;
         poly_done  <= 1'b0;
         range_err  <= 1'b0;
         index_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         poly_done <= wr && last;
         if (wr) begin
            pair_count <= pair_count + 8'd1;
            if (bad(bus.in_coef0) || bad(bus.in_coef1))
               range_err <= 1'b1;
            if (bus.in_index != {8'b0, pair_count})
               index_err <= 1'b1;
         end
         if (ovf) overflow <= 1'b1;
      end
   end

   // Raw 12-bit values are kept even when out of range.
   always_ff @(posedge clk) begin
      if (wr) begin
         even_mem[row] <= bus.in_coef0[11:0];
         odd_mem[row]  <= bus.in_coef1[11:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en)
            bus.rd_data <= bus.rd_addr[0] ? odd_mem[bus.rd_addr[7:1]]
                                          : even_mem[bus.rd_addr[7:1]];
      end
   end

endmodule

// File: tb/tb_poly_collect12.sv
// Directed self-checking bench for poly_collect12.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_poly_collect12;
   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic [7:0] pair_count;
   logic       full, poly_done, range_err, index_err, overflow;
   int         n_pass = 0;
   int         n_total = 0;
   int         done_cnt = 0;
   int         d0;

   poly_collect12_if bus ();

   poly_collect12 dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .bus        (bus.slave),
      .pair_count (pair_count),
      .full       (full),
      .poly_done  (poly_done),
      .range_err  (range_err),
      .index_err  (index_err),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (poly_done) done_cnt++;

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic push(input logic [15:0] c0, input logic [15:0] c1,
                       input logic [15:0] idx);
      bus.in_valid = 1'b1;
      bus.in_coef0 = c0;
      bus.in_coef1 = c1;
      bus.in_index = idx;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] a,
                     input logic [11:0] exp);
      bus.rd_en   = 1'b1;
      bus.rd_addr = a;
      @(negedge clk);
      check(tag, {4'b0, bus.rd_data}, {4'b0, exp});
      bus.rd_en = 1'b0;
   endtask

   task automatic fill(input int n);
      for (int i = 0; i < n; i++)
         push(16'(2 * i), 16'(2 * i + 1), 16'(i));
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic flags0(input string tag);
      check({tag, "_rerr"}, {15'b0, range_err}, 16'd0);
      check({tag, "_ierr"}, {15'b0, index_err}, 16'd0);
      check({tag, "_ovf"},  {15'b0, overflow},  16'd0);
   endtask

   initial begin
      reset = 1'b1;
      clear = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_coef0 = '0;
      bus.in_coef1 = '0;
      bus.in_index = '0;
      bus.rd_en    = 1'b0;
      bus.rd_addr  = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_count", {8'b0, pair_count}, 16'd0);
      check("rst_full",  {15'b0, full}, 16'd0);
      check("rst_done",  {15'b0, poly_done}, 16'd0);
      check("rst_rdata", {4'b0, bus.rd_data}, 16'd0);
      check("rst_rvalid", {15'b0, bus.rd_valid}, 16'd0);
      flags0("rst");
      reset = 1'b0;
      @(negedge clk);

      // full polynomial, back to back
      d0 = done_cnt;
      fill(128);
      check("fill_full",  {15'b0, full}, 16'd1);
      check("fill_count", {8'b0, pair_count}, 16'd128);
      check("fill_done",  {15'b0, poly_done}, 16'd1);
      @(negedge clk);
      check("fill_done_low", {15'b0, poly_done}, 16'd0);
      check("fill_done_cnt", 16'(done_cnt - d0), 16'd1);
      rd("fill_rd0", 8'd0, 12'd0);
      check("fill_rvalid", {15'b0, bus.rd_valid}, 16'd1);
      rd("fill_rd127", 8'd127, 12'd127);
      rd("fill_rd255", 8'd255, 12'd255);
      flags0("fill");

      // write while full
      push(16'd7, 16'd7, 16'd128);
      check("ovf_flag",  {15'b0, overflow}, 16'd1);
      check("ovf_count", {8'b0, pair_count}, 16'd128);
      rd("ovf_rd0", 8'd0, 12'd0);
      rd("ovf_rd1", 8'd1, 12'd1);
      check("ovf_done_cnt", 16'(done_cnt - d0), 16'd1);

      // clear collides with pair 50
      do_clear();
      for (int i = 0; i < 50; i++)
         push(i == 3 ? 16'd4000 : 16'(2 * i), 16'(2 * i + 1), 16'(i));
      check("clr_pre_rerr", {15'b0, range_err}, 16'd1);
      clear = 1'b1;
      push(16'h111, 16'h222, 16'd50);
      clear = 1'b0;
      check("clr_count", {8'b0, pair_count}, 16'd0);
      check("clr_full",  {15'b0, full}, 16'd0);
      flags0("clr");
      rd("clr_rd100", 8'd100, 12'd100);
      rd("clr_rd101", 8'd101, 12'd101);
      push(16'hABC, 16'h123, 16'd0);
      check("clr_ierr_after", {15'b0, index_err}, 16'd0);
      check("clr_count1", {8'b0, pair_count}, 16'd1);
      rd("clr_rd0", 8'd0, 12'hABC);
      rd("clr_rd1", 8'd1, 12'h123);

      // range check boundaries
      do_clear();
      fill(5);
      push(16'd3329, 16'd3328, 16'd5);
      check("rng_set", {15'b0, range_err}, 16'd1);
      push(16'd12, 16'd13, 16'd6);
      check("rng_sticky", {15'b0, range_err}, 16'd1);
      check("rng_ierr", {15'b0, index_err}, 16'd0);
      rd("rng_rd10", 8'd10, 12'hD01);
      rd("rng_rd11", 8'd11, 12'hD00);
      do_clear();
      push(16'd0, 16'h1005, 16'd0);
      check("rng_hi_bits", {15'b0, range_err}, 16'd1);
      rd("rng_rd1_raw", 8'd1, 12'h005);
      do_clear();
      push(16'd4095, 16'd3328, 16'd0);
      check("rng_4095", {15'b0, range_err}, 16'd1);
      do_clear();
      push(16'd3328, 16'd0, 16'd0);
      check("rng_3328_ok", {15'b0, range_err}, 16'd0);

      // pair index skip
      do_clear();
      push(16'h11, 16'h22, 16'd0);
      push(16'h33, 16'h44, 16'd1);
      check("idx_ok", {15'b0, index_err}, 16'd0);
      push(16'h55, 16'h66, 16'd3);
      check("idx_err", {15'b0, index_err}, 16'd1);
      check("idx_count", {8'b0, pair_count}, 16'd3);
      rd("idx_rd4", 8'd4, 12'h55);
      rd("idx_rd5", 8'd5, 12'h66);

      // read and write same location in one cycle
      do_clear();
      bus.rd_en   = 1'b1;
      bus.rd_addr = 8'd0;
      push(16'h777, 16'h778, 16'd0);
      check("rw_old", {4'b0, bus.rd_data}, 16'h011);
      bus.rd_en = 1'b0;
      rd("rw_new", 8'd0, 12'h777);
      @(negedge clk);
      check("rv_drop", {15'b0, bus.rd_valid}, 16'd0);
      check("rd_hold", {4'b0, bus.rd_data}, 16'h777);

      // async reset mid-collection
      do_clear();
      fill(60);
      #2 reset = 1'b1;
      #1;
      check("arst_count", {8'b0, pair_count}, 16'd0);
      check("arst_rdata", {4'b0, bus.rd_data}, 16'd0);
      check("arst_full", {15'b0, full}, 16'd0);
      flags0("arst");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      d0 = done_cnt;
      fill(128);
      check("re_full",  {15'b0, full}, 16'd1);
      check("re_count", {8'b0, pair_count}, 16'd128);
      @(negedge clk);
      check("re_done_cnt", 16'(done_cnt - d0), 16'd1);
      flags0("re");
      rd("re_rd200", 8'd200, 12'd200);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
